apb_reg_slave: RTL

- APB completer that sits directly downstream of the AHB-to-APB bridge and connects to one PSELx bit of that bridge.
- Implements a small word-addressed register bank with a configurable number of wait states and PSLVERR reporting.
- Register 1 is exported as a control word that drives peripheral logic.
- Used as the standard endpoint for bridge integration and for the UVM environment.

---
 rtl/apb_reg_slave.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_reg_slave
// Brief    : APB completer with a word-addressed register bank, programmable
//            wait states and PSLVERR reporting; register 1 drives CTRL_OUT.
// Revision : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h100),
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA5B0_0001)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] CTRL_OUT
);

    localparam int                    c_idx_w     = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = BASE_ADDR + ADDR_WIDTH'(4 * NUM_REGS - 1);
    localparam logic [3:0]            c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic [c_idx_w-1:0]      r_idx;
    logic                    r_write;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_setup;
    logic                    w_access;
    logic                    w_cap;
    logic                    w_we;
    logic                    w_pready_nxt;
    logic                    w_pslverr_nxt;
    logic [DATA_WIDTH-1:0]   w_prdata_nxt;

    logic [ADDR_WIDTH-1:0]   w_off;
    logic [c_idx_w-1:0]      w_idx;
    logic                    w_err;
    logic                    w_unused;
    logic [DATA_WIDTH-1:0]   w_regs [NUM_REGS];

    // Decode of the live bus; only consumed on the edge that samples a setup phase
    assign w_off    = PADDR - BASE_ADDR;
    assign w_idx    = w_off[c_idx_w+1:2];
    assign w_err    = (PADDR < BASE_ADDR) || (PADDR > c_last_addr) ||
                      (PADDR[1:0] != 2'b00) || (PWRITE && (w_idx == '0));
    assign w_unused = &{1'b0, w_off[ADDR_WIDTH-1:c_idx_w+2], w_off[1:0]};

    assign w_setup  = PSEL && !PENABLE;
    assign w_access = PSEL && PENABLE;

    assign w_regs[0] = ID_VALUE;
    assign CTRL_OUT  = w_regs[1];

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_regs
            logic [DATA_WIDTH-1:0] r_reg;
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    r_reg <= '0;
                end else if (w_we && (r_idx == c_idx_w'(gi))) begin
                    r_reg <= r_wdata;
                end
            end
            assign w_regs[gi] = r_reg;
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = '0;
        w_cap         = 1'b0;
        w_we          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cap = w_setup;
            end
            S_WAIT: begin
                if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (PENABLE) begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt   = S_RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = r_err;
                        w_prdata_nxt  = r_err ? '0 : w_regs[r_idx];
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            S_RESP: begin
                w_we        = w_access && r_write && !r_err;
                w_cap       = w_setup;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Shared setup handling for IDLE and back-to-back restart from RESP
        if (w_cap) begin
            if (WAIT_CYCLES == 0) begin
                w_state_nxt   = S_RESP;
                w_pready_nxt  = 1'b1;
                w_pslverr_nxt = w_err;
                w_prdata_nxt  = w_err ? '0 : w_regs[w_idx];
            end else begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = c_wait_load;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            PREADY  <= w_pready_nxt;
            PSLVERR <= w_pslverr_nxt;
            PRDATA  <= w_prdata_nxt;
            if (w_cap) begin
                r_idx   <= w_idx;
                r_write <= PWRITE;
                r_err   <= w_err;
                r_wdata <= PWDATA;
            end
        end
    end

endmodule
`default_nettype wire
